// File: rtl/ctrl_flow_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_flow_pkg
//   Shared definitions for the CALL/RET sequencer:
//     - instruction op encodings presented on req_op
//     - fault codes reported on fault_code
//     - sequencer FSM state type
//     - default program-counter and stack-pointer widths
// ----------------------------------------------------------------------------
package ctrl_flow_pkg;

    localparam int PC_W_DEF = 19;
    localparam int SP_W_DEF = 8;

    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP_RD = 3'd2,
        POP_WB = 3'd3,
        RESP   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/return_stack_ram.sv
// ----------------------------------------------------------------------------
// return_stack_ram
//   Return-address storage: 2**AW entries of DW bits, one write port and one
//   synchronous read port (rdata valid the cycle after re). No reset; contents
//   are only meaningful once written.
// Ports
//   clk    in   1   clock
//   we     in   1   write enable
//   waddr  in   AW  write address
//   wdata  in   DW  write data
//   re     in   1   read enable
//   raddr  in   AW  read address
//   rdata  out  DW  registered read data
// ----------------------------------------------------------------------------
module return_stack_ram #(
    parameter int AW = 8,
    parameter int DW = 19
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/call_ret_sequencer.sv
// ----------------------------------------------------------------------------
// call_ret_sequencer
//   Multi-cycle CALL/RET controller with an internal return-address stack.
//   CALL pushes req_pc+1 and jumps to req_addr; RET pops the top entry into
//   new_pc. Overflow, underflow and illegal ops are rejected at acceptance
//   and reported with a fault pulse, leaving all state untouched.
// Ports
//   clk         in   1       clock
//   rst_n       in   1       asynchronous active-low reset
//   req_valid   in   1       instruction presented by decode
//   req_ready   out  1       high only while idle
//   req_op      in   2       01 CALL, 10 RET, others illegal
//   req_addr    in   PC_W    CALL target
//   req_pc      in   PC_W    PC of the instruction
//   done_valid  out  1       one-cycle completion pulse
//   new_pc      out  PC_W    next PC, held between completions
//   sp          out  SP_W    stack pointer (grows downward)
//   depth       out  SP_W+1  entries on the stack
//   fault       out  1       completion was a rejection
//   fault_code  out  2       01 overflow, 10 underflow, 11 illegal
// ----------------------------------------------------------------------------
module call_ret_sequencer
    import ctrl_flow_pkg::*;
#(
    parameter int              PC_W    = PC_W_DEF,
    parameter int              SP_W    = SP_W_DEF,
    parameter int              DEPTH   = 2**SP_W,
    parameter logic [SP_W-1:0] SP_INIT = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [PC_W-1:0] req_addr,
    input  logic [PC_W-1:0] req_pc,
    output logic            done_valid,
    output logic [PC_W-1:0] new_pc,
    output logic [SP_W-1:0] sp,
    output logic [SP_W:0]   depth,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam logic [SP_W:0] FULL_DEPTH = (SP_W+1)'(DEPTH);

    seq_state_t      state;
    logic [PC_W-1:0] cap_addr;
    logic [PC_W-1:0] cap_pc;
    logic            accept;

    logic            ram_we;
    logic [SP_W-1:0] ram_waddr;
    logic [PC_W-1:0] ram_wdata;
    logic            ram_re;
    logic [SP_W-1:0] ram_raddr;
    logic [PC_W-1:0] ram_rdata;

    assign accept = req_valid && req_ready;

    // RAM controls are decoded from the state register so that an async
    // reset during PUSH immediately suppresses the pending write.
    assign ram_we    = (state == PUSH);
    assign ram_waddr = sp;
    assign ram_wdata = cap_pc + PC_W'(1);
    assign ram_re    = (state == POP_RD);
    assign ram_raddr = sp + SP_W'(1);

    return_stack_ram #(
        .AW (SP_W),
        .DW (PC_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Captured request operands; data only, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_addr <= req_addr;
            cap_pc   <= req_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sp         <= SP_INIT;
            depth      <= '0;
            new_pc     <= '0;
            done_valid <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            req_ready  <= 1'b1;
        end else begin
            unique case (state)
                // Acceptance: faults are decided here from the live request.
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        case (req_op)
                            OP_CALL: begin
                                if (depth == FULL_DEPTH) begin
                                    fault      <= 1'b1;
                                    fault_code <= FAULT_OVERFLOW;
                                    done_valid <= 1'b1;
                                    state      <= RESP;
                                end else begin
                                    fault      <= 1'b0;
                                    fault_code <= FAULT_NONE;
                                    state      <= PUSH;
                                end
                            end
                            OP_RET: begin
                                if (depth == '0) begin
                                    fault      <= 1'b1;
                                    fault_code <= FAULT_UNDERFLOW;
                                    done_valid <= 1'b1;
                                    state      <= RESP;
                                end else begin
                                    fault      <= 1'b0;
                                    fault_code <= FAULT_NONE;
                                    state      <= POP_RD;
                                end
                            end
                            default: begin
                                fault      <= 1'b1;
                                fault_code <= FAULT_ILLEGAL;
                                done_valid <= 1'b1;
                                state      <= RESP;
                            end
                        endcase
                    end
                end
                // Push: RAM write commits on this edge alongside sp/depth.
                PUSH: begin
                    sp         <= sp - SP_W'(1);
                    depth      <= depth + (SP_W+1)'(1);
                    new_pc     <= cap_addr;
                    done_valid <= 1'b1;
                    state      <= RESP;
                end
                // Pop read: RAM samples mem[sp+1] on this edge.
                POP_RD: begin
                    sp    <= sp + SP_W'(1);
                    state <= POP_WB;
                end
                // Pop writeback: registered read data becomes the new PC.
                POP_WB: begin
                    new_pc     <= ram_rdata;
                    depth      <= depth - (SP_W+1)'(1);
                    done_valid <= 1'b1;
                    state      <= RESP;
                end
                // Response: single-cycle done pulse, then ready again.
                RESP: begin
                    done_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    done_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
